alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU between N_REQ requesters (e.g. execute path,
//  branch comparator, address generator) in the multi-cycle core variant.
//  Arbitrates round-robin, latches the winner's operands, drives the ALU for
//  one cycle, and registers the result/zero flag.
//  Returns the registered result to the winner over a valid/ready handshake.
//  Sits between requester stages and the ALU instance; the ALU itself is unchanged.
// PARAMETERS
//  N_REQ   2    number of requesters (2..8); ID_W = $clog2(N_REQ) is a localparam
//  W       32   operand/result width
// PORTS
//  clk        in   1          rising-edge clock, single clock domain
//  rst_n      in   1          synchronous reset, active-low
//  req_valid  in   N_REQ      per-requester operation request
//  req_ready  out  N_REQ      one-hot accept pulse; request i is taken when valid&ready
//  req_a      in   N_REQ*W    operand A, requester i at [i*W +: W]
//  req_b      in   N_REQ*W    operand B, same packing
//  req_ctl    in   N_REQ*4    ALU control, requester i at [i*4 +: 4]
//  alu_a      out  W          to ALU operand A
//  alu_b      out  W          to ALU operand B
//  alu_ctl    out  4          to ALU control (0000 AND, 0001 OR, 0010 ADD, 0110 SUB)
//  alu_result in   W          from ALU, combinational on alu_a/alu_b/alu_ctl
//  alu_zero   in   1          from ALU, 1 when SUB operands are equal
//  rsp_valid  out  1          registered result available
//  rsp_ready  in   1          consumer accepts the response
//  rsp_id     out  ID_W       index of the requester owning the response
//  rsp_result out  W          registered ALU result
//  rsp_zero   out  1          registered ALU zero flag
// BEHAVIOUR
//  - FSM states: IDLE -> ISSUE -> RESP -> IDLE.
//  - IDLE: if any req_valid, grant the first valid index at or after rr_ptr,
//    wrapping modulo N_REQ. Pulse req_ready[grant] for this cycle only.
//    On that edge, latch a/b/ctl/id into op registers and go to ISSUE.
//    No request: stay in IDLE with req_ready all 0.
//  - ISSUE (1 cycle): drive alu_a/b/ctl from op registers.
//    At the edge, capture alu_result/alu_zero into rsp_result/rsp_zero.
//    Set rsp_valid=1 and go to RESP.
//  - RESP: hold rsp_* stable while rsp_valid&&!rsp_ready.
//    On rsp_ready: clear rsp_valid, set rr_ptr = (rsp_id+1) mod N_REQ, go to IDLE.
//  - Latency: accept at cycle 0; rsp_valid is high in cycle 2.
//    Throughput: at most one operation per 3 cycles.
//  - Only one operation is in flight. req_ready stays 0 in ISSUE and RESP.
//  - Requester inputs are don't-care after the accept edge. A requester may drop
//    req_valid before it is granted; no state is affected.
//  - alu_a/alu_b/alu_ctl are driven 0 outside ISSUE.
//  - req_ctl is forwarded unmodified; unsupported codes are not flagged.
//    Whatever the ALU returns is passed through.
//  - Reset (rst_n=0 at an edge) is honoured in any state: FSM=IDLE, rr_ptr=0,
//    rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, op registers=0,
//    req_ready=0. An in-flight operation is dropped with no response.
//  - Simultaneous requests: round-robin only. A continuously requesting index
//    waits at most N_REQ-1 grants.
// TESTING
//  1 req_valid=01, a=5, b=7, ctl=0010 -> req_ready=01 @c0; rsp_valid @c2,
//    rsp_result=12, rsp_zero=0, rsp_id=0
//  2 req_valid=11 after reset, rsp_ready=1 -> first grant id0, next grant id1,
//    then id0 again (strict alternation)
//  3 id1 SUB a=9, b=9, ctl=0110 -> rsp_result=0, rsp_zero=1, rsp_id=1
//  4 rsp_ready=0 for 3 cycles in RESP -> rsp_* stable, req_ready=00 throughout;
//    back to IDLE the cycle after rsp_ready=1
//  5 rst_n=0 during ISSUE -> next cycle: rsp_valid=0, FSM IDLE, rr_ptr=0;
//    no response for the dropped op
//  6 req0 AND 0xF0F0&0x0FF0 then OR same operands -> 0x00F0 then 0xFFF0;
//    operands changed after accept do not alter the result

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter_if
// Description : Requester, ALU and response bundle for the shared-ALU arbiter.
//               The slave modport is the arbiter's view; master is the
//               environment (requesters, ALU and response consumer).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int W     = 32
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ*4-1:0] req_ctl;
    logic [W-1:0]       alu_a;
    logic [W-1:0]       alu_b;
    logic [3:0]         alu_ctl;
    logic [W-1:0]       alu_result;
    logic               alu_zero;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [W-1:0]       rsp_result;
    logic               rsp_zero;

    modport slave (
        input  req_valid, req_a, req_b, req_ctl, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctl, rsp_valid, rsp_id, rsp_result, rsp_zero
    );

    modport master (
        output req_valid, req_a, req_b, req_ctl, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctl, rsp_valid, rsp_id, rsp_result, rsp_zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one combinational ALU between N_REQ
//               requesters. One operation in flight: accept, issue to the ALU
//               for a cycle, then hold the registered result until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int N_REQ = 2,
    parameter int W     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id;
    logic [W-1:0]       r_op_a;
    logic [W-1:0]       r_op_b;
    logic [3:0]         r_op_ctl;
    logic [W-1:0]       r_rsp_result;
    logic               r_rsp_zero;
    logic               w_found;
    logic [ID_W-1:0]    w_grant_id;
    logic [N_REQ-1:0]   w_ready;
    logic               w_accept;
    logic [ID_W-1:0]    w_ptr_nxt;

    // Round-robin search: lowest offset from r_rr_ptr wins, so scan offsets high to low.
    always_comb begin
        int idx;
        idx        = 0;
        w_found    = 1'b0;
        w_grant_id = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (bus.req_valid[idx]) begin
                w_found    = 1'b1;
                w_grant_id = ID_W'(idx);
            end
        end
    end

    // One-hot accept pulse, only in IDLE and never while reset is asserted.
    always_comb begin
        w_ready = '0;
        if (rst_n && (r_state == S_IDLE) && w_found) begin
            w_ready[w_grant_id] = 1'b1;
        end
    end

    assign w_accept  = (r_state == S_IDLE) && w_found;
    assign w_ptr_nxt = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> ISSUE -> RESP -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch on accept, result capture in ISSUE, pointer advance on consume.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_ctl     <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_a   <= bus.req_a[w_grant_id*W +: W];
                r_op_b   <= bus.req_b[w_grant_id*W +: W];
                r_op_ctl <= bus.req_ctl[w_grant_id*4 +: 4];
                r_id     <= w_grant_id;
            end
            if (r_state == S_ISSUE) begin
                r_rsp_result <= bus.alu_result;
                r_rsp_zero   <= bus.alu_zero;
            end
            if ((r_state == S_RESP) && bus.rsp_ready) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.alu_a      = (r_state == S_ISSUE) ? r_op_a   : '0;
    assign bus.alu_b      = (r_state == S_ISSUE) ? r_op_b   : '0;
    assign bus.alu_ctl    = (r_state == S_ISSUE) ? r_op_ctl : 4'd0;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_zero   = r_rsp_zero;
endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Directed plus randomized bench for alu_share_arbiter with a
//               behavioural ALU and a round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
    localparam int N = 3;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // Reference state: expected round-robin pointer and per-requester operands.
    int         exp_ptr;
    logic [W-1:0] a_v [N];
    logic [W-1:0] b_v [N];
    logic [3:0]   c_v [N];

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.N_REQ(N), .W(W)) bus ();

    alu_share_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [W-1:0] alu_f(input logic [3:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return a ^ b;
        endcase
    endfunction

    // Behavioural combinational ALU attached to the arbiter.
    always_comb begin
        bus.alu_result = alu_f(bus.alu_ctl, bus.alu_a, bus.alu_b);
        bus.alu_zero   = (alu_f(bus.alu_ctl, bus.alu_a, bus.alu_b) == '0);
    end

    function automatic int pick(input logic [N-1:0] m, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (m[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = a_v[i];
            bus.req_b[i*W +: W] = b_v[i];
            bus.req_ctl[i*4 +: 4] = c_v[i];
        end
        bus.req_valid = mask;
    endtask

    task automatic scramble();
        for (int i = 0; i < N; i++) begin
            a_v[i] = W'($urandom);
            b_v[i] = W'($urandom);
            c_v[i] = 4'($urandom);
        end
    endtask

    // One full transaction, entered and left at a falling edge in IDLE.
    task automatic run_op(input logic [N-1:0] mask, input int wait_n);
        int g;
        logic [N-1:0] oh;
        logic [W-1:0] ea, eb, er;
        logic [3:0]   ec;
        drive(mask);
        bus.rsp_ready = 1'b0;
        #1;
        g  = pick(mask, exp_ptr);
        oh = '0;
        oh[g] = 1'b1;
        ea = a_v[g];
        eb = b_v[g];
        ec = c_v[g];
        er = alu_f(ec, ea, eb);
        chk("grant", 64'(bus.req_ready), 64'(oh));
        @(negedge clk);
        scramble();
        drive(mask);
        #1;
        chk("issue_ready", 64'(bus.req_ready), 64'd0);
        chk("issue_alu_a", 64'(bus.alu_a), 64'(ea));
        chk("issue_alu_b", 64'(bus.alu_b), 64'(eb));
        chk("issue_alu_ctl", 64'(bus.alu_ctl), 64'(ec));
        chk("issue_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rsp_id", 64'(bus.rsp_id), 64'(g));
        chk("rsp_result", 64'(bus.rsp_result), 64'(er));
        chk("rsp_zero", 64'(bus.rsp_zero), 64'(er == '0));
        chk("rsp_ready_out", 64'(bus.req_ready), 64'd0);
        for (int w = 0; w < wait_n; w++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
            chk("hold_result", 64'(bus.rsp_result), 64'(er));
            chk("hold_id", 64'(bus.rsp_id), 64'(g));
            chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = '0;
        exp_ptr = (g + 1) % N;
        #1;
        chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("idle_alu_a", 64'(bus.alu_a), 64'd0);
    endtask

    initial begin
        #500000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_ptr       = 0;
        rst_n         = 1'b0;
        bus.rsp_ready = 1'b0;
        scramble();
        drive('1);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
        chk("rst_rsp_zero", 64'(bus.rsp_zero), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
        rst_n = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);

        // Two contenders alternate strictly: 0, 1, 0.
        for (int i = 0; i < 3; i++) begin
            scramble();
            run_op(3'b011, 0);
        end
        exp_ptr = 1;

        // Single requester ADD 5 + 7.
        a_v[0] = 32'd5; b_v[0] = 32'd7; c_v[0] = 4'b0010;
        run_op(3'b001, 0);

        // Requester 1 SUB of equal operands raises zero.
        a_v[1] = 32'd9; b_v[1] = 32'd9; c_v[1] = 4'b0110;
        run_op(3'b010, 0);

        // Consumer stalls for three cycles.
        scramble();
        run_op(3'b111, 3);

        // AND then OR on the same operands; operands scrambled after accept.
        a_v[0] = 32'h0000_F0F0; b_v[0] = 32'h0000_0FF0; c_v[0] = 4'b0000;
        run_op(3'b001, 0);
        a_v[0] = 32'h0000_F0F0; b_v[0] = 32'h0000_0FF0; c_v[0] = 4'b0001;
        run_op(3'b001, 1);

        // Reset during ISSUE drops the operation and clears the pointer.
        scramble();
        drive(3'b100);
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        chk("drop_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("drop_alu_a", 64'(bus.alu_a), 64'd0);
        chk("drop_req_ready", 64'(bus.req_ready), 64'd0);
        rst_n = 1'b1;
        exp_ptr = 0;
        @(negedge clk);
        @(negedge clk);
        chk("drop_no_rsp", 64'(bus.rsp_valid), 64'd0);
        scramble();
        run_op(3'b111, 0);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            scramble();
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 4))
                    0: c_v[i] = 4'b0000;
                    1: c_v[i] = 4'b0001;
                    2: c_v[i] = 4'b0010;
                    3: c_v[i] = 4'b0110;
                    default: c_v[i] = 4'($urandom);
                endcase
                if ($urandom_range(0, 3) == 0) b_v[i] = a_v[i];
            end
            run_op(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
